// File: rtl/row_clear_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : row_clear_scanner
// Description : Requests each playfield row bottom-up, flags rows with no
//               background cell and reports a full-row mask and count.
// Revision    : 1.0  initial release
// ============================================================================
module row_clear_scanner #(
    parameter int          NUM_ROWS = 20,
    parameter logic [15:0] BG_COLOR = 16'h000f,
    parameter int          TIMEOUT  = 1023
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            row_ready,
    input  logic [9:0][15:0]                read_reg,
    output logic                            row_ld,
    output logic [7:0]                      row,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_ROWS-1:0]             full_mask,
    output logic [$clog2(NUM_ROWS+1)-1:0]   full_count,
    output logic                            timeout_err
);

    localparam int CNT_W  = $clog2(NUM_ROWS + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_CHECK = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [9:0][15:0]      r_cells;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic                  w_row_full;
    logic [NUM_ROWS-1:0]   w_row_bit;

    // Dropped in the row_ready cycle so the read path never sees a second launch.
    assign row_ld = (r_state == ST_REQ) && !row_ready;

    always_comb begin
        w_row_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (r_cells[i] == BG_COLOR) begin
                w_row_full = 1'b0;
            end
        end
    end

    assign w_row_bit = NUM_ROWS'(1) << row;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cells     <= '0;
            r_wait_cnt  <= '0;
            row         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            full_mask   <= '0;
            full_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        full_mask   <= '0;
                        full_count  <= '0;
                        timeout_err <= 1'b0;
                        row         <= 8'(NUM_ROWS - 1);
                        r_wait_cnt  <= '0;
                        busy        <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (row_ready) begin
                        r_cells <= read_reg;
                        r_state <= ST_CHECK;
                    end else if (r_wait_cnt == WAIT_W'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        r_state     <= ST_NEXT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_row_full) begin
                        full_mask <= full_mask | w_row_bit;
                        if (full_count < CNT_W'(NUM_ROWS)) begin
                            full_count <= full_count + 1'b1;
                        end
                    end
                    r_state <= ST_NEXT;
                end
                ST_NEXT: begin
                    r_wait_cnt <= '0;
                    if (row == 8'd0) begin
                        // done/busy flip on entry so they are visible during the DONE state
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        row     <= row - 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
